regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: req0 (ALU) and req1 (load unit).
- Each requester uses a valid/ready handshake. The block arbitrates round-robin, or fixed-priority if configured.
- The winner is registered into a one-entry output stage that drives the regfile chip_en / write-enable / write-address / write-data pins.
- Also publishes a pending-write mask for hazard logic and a saturating conflict counter.

---
 rtl/regfile_wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: two valid/ready requesters share one
// regfile write port through a one-entry output stage. Round-robin or
// fixed-priority arbitration, pending-write mask and saturating conflict count.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIXED_PRIO = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              rf_stall,
    output logic              rf_chip_en,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_wreg,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [31:0]       pend_mask,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              prefer1_q, prefer1_d;   // 1: req1 wins the next tie
    logic [31:0]       pend_q, pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              grant0, grant1;
    logic              can_accept;
    logic              hs0, hs1, hs;
    logic              drain;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic [31:0]       sel_onehot;

    // Combinational grant from the valids and the round-robin pointer
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if (FIXED_PRIO != 0 || !prefer1_q) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    // The stage can take a new entry when empty or when its entry commits now;
    // readies are forced low while reset is asserted.
    assign can_accept = (state_q == EMPTY) || !rf_stall;
    assign req0_ready = reset & can_accept & grant0;
    assign req1_ready = reset & can_accept & grant1;
    assign hs0        = req0_valid & req0_ready;
    assign hs1        = req1_valid & req1_ready;
    assign hs         = hs0 | hs1;
    assign drain      = (state_q == FULL) && !rf_stall;
    assign sel_rd     = hs1 ? req1_rd : req0_rd;
    assign sel_data   = hs1 ? req1_data : req0_data;

    // One-hot of the accepted destination; x0 never shows as pending
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_onehot
            if (gi == 0) begin : g_zero
                assign sel_onehot[gi] = 1'b0;
            end else begin : g_bit
                assign sel_onehot[gi] = (32'(sel_rd) == 32'(gi));
            end
        end
    endgenerate

    // State register plus datapath flops, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= EMPTY;
            wreg_q    <= '0;
            wdata_q   <= '0;
            prefer1_q <= 1'b0;
            pend_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
            prefer1_q <= prefer1_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next state of the output stage: load on handshake, empty on commit
    always_comb begin
        state_d = state_q;
        if (hs) begin
            state_d = FULL;
        end else if (drain) begin
            state_d = EMPTY;
        end
    end

    // Next values of entry, pending mask, pointer and conflict counter
    always_comb begin
        wreg_d    = wreg_q;
        wdata_d   = wdata_q;
        pend_d    = pend_q;
        prefer1_d = prefer1_q;
        cnt_d     = cnt_q;
        if (hs) begin
            wreg_d    = sel_rd;
            wdata_d   = sel_data;
            pend_d    = sel_onehot;
            prefer1_d = hs0;
        end else if (drain) begin
            pend_d = '0;
        end
        if (req0_valid && req1_valid && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Regfile pin outputs decoded from the stage state
    always_comb begin
        rf_chip_en   = (state_q == FULL);
        rf_write_en  = (state_q == FULL) && (wreg_q != '0);
        rf_wreg      = wreg_q;
        rf_wdata     = wdata_q;
        pend_mask    = pend_q;
        conflict_cnt = cnt_q;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios followed by randomized
// traffic checked against a transaction-level model of the arbiter.
module tb_regfile_wb_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int FIXED_PRIO = 0;
    localparam int CNT_W      = 4;
    localparam int CMAX       = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [ADDR_W-1:0] req0_rd, req1_rd;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              rf_stall;
    logic              rf_chip_en, rf_write_en;
    logic [ADDR_W-1:0] rf_wreg;
    logic [DATA_W-1:0] rf_wdata;
    logic [31:0]       pend_mask;
    logic [CNT_W-1:0]  conflict_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural regfile attached to the write port
    logic              rf_clr;
    logic [DATA_W-1:0] tb_rf [32];

    regfile_wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIXED_PRIO(FIXED_PRIO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
        .rf_stall(rf_stall), .rf_chip_en(rf_chip_en), .rf_write_en(rf_write_en),
        .rf_wreg(rf_wreg), .rf_wdata(rf_wdata), .pend_mask(pend_mask), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) tb_rf[i] <= '0;
        end else if (rf_chip_en && rf_write_en && !rf_stall) begin
            tb_rf[rf_wreg] <= rf_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; rf_clr = 1'b1; rf_stall = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_rd = '0; req1_rd = '0; req0_data = '0; req1_data = '0;
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b1;
        #4;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got=%b exp=0", req0_ready); end
        checks++; if (rf_chip_en !== 1'b0) begin errors++; $display("FAIL reset_chip_en got=%b exp=0", rf_chip_en); end
        tick();
        reset = 1'b1; rf_clr = 1'b0; req0_valid = 1'b0;
        #4;
        checks++; if (rf_chip_en !== 1'b0 || rf_write_en !== 1'b0) begin errors++; $display("FAIL idle_en got=%b%b exp=00", rf_chip_en, rf_write_en); end
        checks++; if (rf_wreg !== '0 || rf_wdata !== '0) begin errors++; $display("FAIL idle_wreg_wdata got=%0d/%h exp=0/0", rf_wreg, rf_wdata); end
        checks++; if (pend_mask !== 32'h0 || conflict_cnt !== '0) begin errors++; $display("FAIL idle_pend_cnt got=%h/%0d exp=0/0", pend_mask, conflict_cnt); end
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got=%b%b exp=00", req0_ready, req1_ready); end
        $display("reset/idle done");
        tick();
    endtask

    task automatic test_single_write();
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'h5;
        #4;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready got=%b%b exp=10", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0;
        #4;
        checks++; if (rf_chip_en !== 1'b1 || rf_write_en !== 1'b1) begin errors++; $display("FAIL single_en got=%b%b exp=11", rf_chip_en, rf_write_en); end
        checks++; if (rf_wreg !== 5'd5 || rf_wdata !== 32'h5) begin errors++; $display("FAIL single_entry got=%0d/%h exp=5/5", rf_wreg, rf_wdata); end
        checks++; if (pend_mask !== 32'h20) begin errors++; $display("FAIL single_pend got=%h exp=20", pend_mask); end
        tick();
        #4;
        checks++; if (tb_rf[5] !== 32'h5) begin errors++; $display("FAIL single_commit got=%h exp=5", tb_rf[5]); end
        checks++; if (rf_chip_en !== 1'b0 || pend_mask !== 32'h0) begin errors++; $display("FAIL single_drain got=%b/%h exp=0/0", rf_chip_en, pend_mask); end
        $display("single write rd=5 data=5");
        tick();
    endtask

    task automatic test_x0();
        req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'hF0F0F0F0;
        #4;
        checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL x0_ready got=%b%b exp=01", req0_ready, req1_ready); end
        tick();
        req1_valid = 1'b0;
        #4;
        checks++; if (rf_chip_en !== 1'b1 || rf_write_en !== 1'b0) begin errors++; $display("FAIL x0_en got=%b%b exp=10", rf_chip_en, rf_write_en); end
        checks++; if (rf_wdata !== 32'hF0F0F0F0 || rf_wreg !== '0) begin errors++; $display("FAIL x0_entry got=%0d/%h exp=0/f0f0f0f0", rf_wreg, rf_wdata); end
        checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL x0_pend got=%h exp=0", pend_mask); end
        tick();
        checks++; if (tb_rf[0] !== '0) begin errors++; $display("FAIL x0_reg0 got=%h exp=0", tb_rf[0]); end
        $display("x0 write req1 data=f0f0f0f0");
    endtask

    task automatic test_round_robin();
        logic [ADDR_W-1:0] exp_wreg;
        req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'hA;
        req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'hB;
        for (int k = 0; k < 4; k++) begin
            #4;
            checks++; if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
                errors++; $display("FAIL rr_grant cyc=%0d got=%b%b exp=%b%b", k, req0_ready, req1_ready, (k % 2 == 0), (k % 2 == 1));
            end
            if (k > 0) begin
                exp_wreg = (k % 2 == 1) ? 5'd1 : 5'd2;
                checks++; if (rf_wreg !== exp_wreg) begin errors++; $display("FAIL rr_wreg cyc=%0d got=%0d exp=%0d", k, rf_wreg, exp_wreg); end
            end
            $display("rr cycle %0d grant=%b%b", k, req1_ready, req0_ready);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #4;
        checks++; if (rf_wreg !== 5'd2) begin errors++; $display("FAIL rr_wreg_last got=%0d exp=2", rf_wreg); end
        checks++; if (conflict_cnt !== CNT_W'(4)) begin errors++; $display("FAIL rr_conflict got=%0d exp=4", conflict_cnt); end
        tick();
        checks++; if (tb_rf[1] !== 32'hA || tb_rf[2] !== 32'hB) begin errors++; $display("FAIL rr_commit got=%h/%h exp=a/b", tb_rf[1], tb_rf[2]); end
    endtask

    task automatic test_stall_hold();
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h77;
        tick();
        req0_valid = 1'b0; rf_stall = 1'b1;
        req1_valid = 1'b1; req1_rd = 5'd8; req1_data = 32'h88;
        for (int k = 0; k < 3; k++) begin
            #4;
            checks++; if (rf_chip_en !== 1'b1 || rf_wreg !== 5'd7 || rf_wdata !== 32'h77) begin
                errors++; $display("FAIL stall_hold cyc=%0d got=%b/%0d/%h exp=1/7/77", k, rf_chip_en, rf_wreg, rf_wdata);
            end
            checks++; if (pend_mask !== 32'h80) begin errors++; $display("FAIL stall_pend cyc=%0d got=%h exp=80", k, pend_mask); end
            checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL stall_ready cyc=%0d got=%b%b exp=00", k, req0_ready, req1_ready); end
            $display("stall cycle %0d", k);
            tick();
        end
        rf_stall = 1'b0;
        #4;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%b exp=1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        #4;
        checks++; if (tb_rf[7] !== 32'h77) begin errors++; $display("FAIL stall_commit got=%h exp=77", tb_rf[7]); end
        checks++; if (rf_wreg !== 5'd8 || pend_mask !== 32'h100) begin errors++; $display("FAIL stall_next got=%0d/%h exp=8/100", rf_wreg, pend_mask); end
        tick();
    endtask

    task automatic test_async_reset();
        req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h99;
        tick();
        req0_valid = 1'b0;
        #4;
        checks++; if (rf_chip_en !== 1'b1 || rf_wreg !== 5'd9) begin errors++; $display("FAIL areset_load got=%b/%0d exp=1/9", rf_chip_en, rf_wreg); end
        reset = 1'b0;
        #1;
        checks++; if (rf_chip_en !== 1'b0 || rf_write_en !== 1'b0 || pend_mask !== 32'h0) begin
            errors++; $display("FAIL areset_clear got=%b%b/%h exp=00/0", rf_chip_en, rf_write_en, pend_mask);
        end
        checks++; if (rf_wreg !== '0 || rf_wdata !== '0 || conflict_cnt !== '0) begin
            errors++; $display("FAIL areset_regs got=%0d/%h/%0d exp=0/0/0", rf_wreg, rf_wdata, conflict_cnt);
        end
        #1;
        reset = 1'b1;
        tick();
        checks++; if (tb_rf[9] !== '0) begin errors++; $display("FAIL areset_nowrite got=%h exp=0", tb_rf[9]); end
        req0_valid = 1'b1; req0_rd = 5'd10; req0_data = 32'h1010;
        req1_valid = 1'b1; req1_rd = 5'd11; req1_data = 32'h1111;
        #4;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL areset_prio got=%b%b exp=10", req0_ready, req1_ready); end
        $display("async reset mid-op done");
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_random();
        logic              p_valid [2];
        logic [ADDR_W-1:0] p_rd    [2];
        logic [DATA_W-1:0] p_data  [2];
        logic [DATA_W-1:0] m_rf    [32];
        logic              m_full;
        logic [ADDR_W-1:0] m_rd;
        logic [DATA_W-1:0] m_data;
        int                m_last, m_conf, win;
        logic              stall, can, e0, e1;
        logic [31:0]       exp_pend;
        int                exp_cnt;

        reset = 1'b0; rf_clr = 1'b1; rf_stall = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        reset = 1'b1; rf_clr = 1'b0;
        m_full = 1'b0; m_rd = '0; m_data = '0; m_last = 1; m_conf = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        for (int i = 0; i < 2; i++) begin p_valid[i] = 1'b0; p_rd[i] = '0; p_data[i] = '0; end

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!p_valid[i] && $urandom_range(0, 99) < 60) begin
                    p_valid[i] = 1'b1;
                    p_rd[i]    = ADDR_W'($urandom_range(0, 31));
                    p_data[i]  = $urandom;
                end
            end
            stall = ($urandom_range(0, 3) == 0);
            req0_valid = p_valid[0]; req0_rd = p_rd[0]; req0_data = p_data[0];
            req1_valid = p_valid[1]; req1_rd = p_rd[1]; req1_data = p_data[1];
            rf_stall = stall;
            #4;
            can = !m_full || !stall;
            win = -1;
            if (p_valid[0] && p_valid[1]) win = (FIXED_PRIO != 0) ? 0 : ((m_last == 0) ? 1 : 0);
            else if (p_valid[0]) win = 0;
            else if (p_valid[1]) win = 1;
            e0 = can && (win == 0);
            e1 = can && (win == 1);
            exp_pend = 32'd0;
            if (m_full && m_rd != '0) begin exp_pend = 32'd1; exp_pend = exp_pend << m_rd; end
            exp_cnt = (m_conf > CMAX) ? CMAX : m_conf;

            checks++; if (req0_ready !== e0 || req1_ready !== e1) begin
                errors++; $display("FAIL rnd_ready cyc=%0d got=%b%b exp=%b%b", c, req0_ready, req1_ready, e0, e1);
            end
            checks++; if (rf_chip_en !== m_full) begin errors++; $display("FAIL rnd_chip_en cyc=%0d got=%b exp=%b", c, rf_chip_en, m_full); end
            if (m_full) begin
                checks++; if (rf_wreg !== m_rd || rf_wdata !== m_data || rf_write_en !== (m_rd != '0)) begin
                    errors++; $display("FAIL rnd_entry cyc=%0d got=%0d/%h/%b exp=%0d/%h/%b", c, rf_wreg, rf_wdata, rf_write_en, m_rd, m_data, (m_rd != '0));
                end
            end
            checks++; if (pend_mask !== exp_pend) begin errors++; $display("FAIL rnd_pend cyc=%0d got=%h exp=%h", c, pend_mask, exp_pend); end
            checks++; if (conflict_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL rnd_conflict cyc=%0d got=%0d exp=%0d", c, conflict_cnt, exp_cnt); end

            if (m_full && !stall && m_rd != '0) m_rf[m_rd] = m_data;
            if (p_valid[0] && p_valid[1]) m_conf++;
            if (e0 || e1) begin
                m_full = 1'b1; m_rd = p_rd[win]; m_data = p_data[win];
                m_last = win; p_valid[win] = 1'b0;
                $display("rnd accept req%0d rd=%0d data=%h", win, m_rd, m_data);
            end else if (!stall) begin
                m_full = 1'b0;
            end
            tick();
        end

        req0_valid = 1'b0; req1_valid = 1'b0; rf_stall = 1'b0;
        if (m_full && m_rd != '0) m_rf[m_rd] = m_data;
        tick();
        tick();
        for (int i = 0; i < 32; i++) begin
            checks++; if (tb_rf[i] !== m_rf[i]) begin errors++; $display("FAIL rnd_regfile r%0d got=%h exp=%h", i, tb_rf[i], m_rf[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_x0();
        test_round_robin();
        test_stall_hold();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
